sfo_hypothesis_sweeper: RTL and testbench
=========================================

// Module: sfo_hypothesis_sweeper
// PURPOSE
//  Initiator for sfo_fft_correlator: sweeps a list of SFO hypotheses over one stored FFT-magnitude frame.
//  Per hypothesis: loads sfo_int/frac with a 1-cycle correlation_reset, streams all FFT bins, collects the result.
//  Tracks the best-scoring hypothesis and reports it with a done pulse.
//  Sits between the per-CFO FFT magnitude buffer and the correlator, in front of the MRR gateway SFO decision logic.
// PARAMETERS
//  FFT_LEN_LOG2    9     log2 of FFT bins streamed per hypothesis
//  POWER_WIDTH     16    FFT magnitude width
//  SFO_INT_WIDTH   9     integer part of SFO hypothesis (bins)
//  SFO_FRAC_WIDTH  16    fractional part of SFO hypothesis
//  CORR_WIDTH      26    correlator result width (13 int + 13 frac)
//  HYP_CNT_WIDTH   8     hypothesis counter width
//  TIMEOUT_CYCLES  256   max WAIT cycles for correlation_out_valid
// PORTS
//  clk               in   1                  clock
//  reset             in   1                  synchronous, active-high
//  start             in   1                  1-cycle pulse, begins sweep; ignored when busy=1
//  sfo_start_int     in   SFO_INT_WIDTH      first hypothesis, integer part
//  sfo_start_frac    in   SFO_FRAC_WIDTH     first hypothesis, fractional part
//  sfo_step_frac     in   SFO_FRAC_WIDTH     per-hypothesis increment (fractional only)
//  num_hypotheses    in   HYP_CNT_WIDTH      hypotheses to test; 0 = empty sweep
//  mag_rd_addr       out  FFT_LEN_LOG2       FFT buffer read address
//  mag_rd_en         out  1                  FFT buffer read enable
//  mag_rd_data       in   POWER_WIDTH        read data, valid 1 cycle after mag_rd_en
//  sfo_int_part      out  SFO_INT_WIDTH      to correlator
//  sfo_frac_part     out  SFO_FRAC_WIDTH     to correlator
//  correlation_reset out  1                  to correlator
//  correlation_update out 1                  to correlator, qualifies fft_mag_out
//  fft_mag_out       out  POWER_WIDTH        to correlator fft_mag_in
//  correlation_in    in   CORR_WIDTH         from correlator correlation_out
//  correlation_valid in   1                  from correlator (sticky until correlation_reset)
//  busy              out  1                  sweep in progress
//  done              out  1                  1-cycle pulse at sweep end
//  best_valid        out  1                  best_* hold a real result
//  best_sfo_int      out  SFO_INT_WIDTH      winning hypothesis integer part
//  best_sfo_frac     out  SFO_FRAC_WIDTH     winning hypothesis fractional part
//  best_corr         out  CORR_WIDTH         winning correlation
//  timeout_seen      out  1                  sticky per sweep: some hypothesis timed out
// BEHAVIOUR
//  Reset (anytime, incl. mid-sweep): state IDLE; all outputs 0 except correlation_reset=1 for that cycle.
//  FSM: IDLE -> LOAD -> STREAM -> DRAIN -> WAIT -> NEXT -> (LOAD | FINISH) -> IDLE.
//  IDLE: on start: latch inputs, hyp=start value, count=0, clear best_valid/timeout_seen, busy=1.
//   num_hypotheses=0: go FINISH directly (done pulse, best_valid=0).
//  LOAD: correlation_reset=1 one cycle; sfo_int/frac_part driven from hyp, held stable until next LOAD.
//  STREAM: mag_rd_en=1, addr 0..2^FFT_LEN_LOG2-1, one per cycle, no bubbles.
//  correlation_update = mag_rd_en delayed 1; fft_mag_out = mag_rd_data (combinational pass-through).
//  DRAIN: 1 cycle after last address so final bin gets its update.
//  WAIT: wait for correlation_valid; timer counts from 0; at TIMEOUT_CYCLES treat result as 0, set timeout_seen.
//  NEXT: compare: if best_valid=0 or result > best_corr (unsigned, strict) capture hyp and result, best_valid=1.
//   Timed-out hypothesis never captured. Ties keep earlier hypothesis.
//   count+1; if count+1 == num_hypotheses -> FINISH else hyp += step -> LOAD.
//  Hyp increment: frac sum in SFO_FRAC_WIDTH+1 bits; carry adds 1 to int; int wraps mod 2^SFO_INT_WIDTH.
//  FINISH: done=1 one cycle, busy=0, best_* held until next start or reset.
//  Per-hypothesis cycle cost: 1 + 2^FFT_LEN_LOG2 + 1 + correlator latency + 1.
//  start during busy: ignored, no effect on sweep. start in FINISH cycle: ignored.
//  correlation_valid outside WAIT: ignored.
// TESTING
//  start, int=4 frac=0, step=0x4000, n=4, bins with peaks at multiples of 4.5 -> best_sfo_int=4, best_frac=0x8000, done once.
//  Protocol check: per hypothesis exactly 1 correlation_reset, 512 correlation_update, addr 0..511 in order.
//  frac=0xC000, step=0x8000, n=3 -> hyps (int,frac) = (5,C000),(6,4000),(6,C000); int wrap from 511 -> 0.
//  Model forces equal corr for all hyps -> first hyp retained; one hyp never valid -> timeout_seen=1, not chosen.
//  n=0 -> done 1 cycle after start, best_valid=0, no correlation_reset/update activity.
//  reset mid-STREAM then fresh start -> busy/done/best_* 0, clean sweep matches golden result; start while busy ignored.

Source files
------------

// File: rtl/sfo_hypothesis_sweeper_if.sv
// Bus bundle between the SFO sweeper, its FFT-magnitude buffer, the correlator and the controller.
// master = sweeper side; slave = everything around it.
interface sfo_hypothesis_sweeper_if #(
  parameter int FFT_LEN_LOG2   = 9,
  parameter int POWER_WIDTH    = 16,
  parameter int SFO_INT_WIDTH  = 9,
  parameter int SFO_FRAC_WIDTH = 16,
  parameter int CORR_WIDTH     = 26,
  parameter int HYP_CNT_WIDTH  = 8
);
  logic                      start;
  logic [SFO_INT_WIDTH-1:0]  sfo_start_int;
  logic [SFO_FRAC_WIDTH-1:0] sfo_start_frac;
  logic [SFO_FRAC_WIDTH-1:0] sfo_step_frac;
  logic [HYP_CNT_WIDTH-1:0]  num_hypotheses;
  logic [FFT_LEN_LOG2-1:0]   mag_rd_addr;
  logic                      mag_rd_en;
  logic [POWER_WIDTH-1:0]    mag_rd_data;
  logic [SFO_INT_WIDTH-1:0]  sfo_int_part;
  logic [SFO_FRAC_WIDTH-1:0] sfo_frac_part;
  logic                      correlation_reset;
  logic                      correlation_update;
  logic [POWER_WIDTH-1:0]    fft_mag_out;
  logic [CORR_WIDTH-1:0]     correlation_in;
  logic                      correlation_valid;
  logic                      busy;
  logic                      done;
  logic                      best_valid;
  logic [SFO_INT_WIDTH-1:0]  best_sfo_int;
  logic [SFO_FRAC_WIDTH-1:0] best_sfo_frac;
  logic [CORR_WIDTH-1:0]     best_corr;
  logic                      timeout_seen;

  modport master (
    input  start, sfo_start_int, sfo_start_frac, sfo_step_frac, num_hypotheses,
    input  mag_rd_data, correlation_in, correlation_valid,
    output mag_rd_addr, mag_rd_en, sfo_int_part, sfo_frac_part,
    output correlation_reset, correlation_update, fft_mag_out,
    output busy, done, best_valid, best_sfo_int, best_sfo_frac, best_corr, timeout_seen
  );

  modport slave (
    output start, sfo_start_int, sfo_start_frac, sfo_step_frac, num_hypotheses,
    output mag_rd_data, correlation_in, correlation_valid,
    input  mag_rd_addr, mag_rd_en, sfo_int_part, sfo_frac_part,
    input  correlation_reset, correlation_update, fft_mag_out,
    input  busy, done, best_valid, best_sfo_int, best_sfo_frac, best_corr, timeout_seen
  );
endinterface

// File: rtl/sfo_hypothesis_sweeper.sv
// Sweeps SFO hypotheses over one stored FFT-magnitude frame through the correlator
// and keeps the best-scoring hypothesis (earliest wins on ties).
module sfo_hypothesis_sweeper #(
  parameter int FFT_LEN_LOG2   = 9,
  parameter int POWER_WIDTH    = 16,
  parameter int SFO_INT_WIDTH  = 9,
  parameter int SFO_FRAC_WIDTH = 16,
  parameter int CORR_WIDTH     = 26,
  parameter int HYP_CNT_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic clk,
  input logic reset,
  sfo_hypothesis_sweeper_if.master bus
);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FFT_LEN_LOG2-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_WAIT, S_NEXT, S_FINISH
  } state_t;

  state_t                    state;
  logic [SFO_FRAC_WIDTH-1:0] step_r;
  logic [HYP_CNT_WIDTH-1:0]  num_r, count;
  logic [FFT_LEN_LOG2-1:0]   addr;
  logic                      rd_en, upd, corr_rst_r;
  logic [SFO_INT_WIDTH-1:0]  hyp_int;
  logic [SFO_FRAC_WIDTH-1:0] hyp_frac;
  logic                      busy_r, done_r, best_valid_r, timeout_r;
  logic [SFO_INT_WIDTH-1:0]  best_int_r;
  logic [SFO_FRAC_WIDTH-1:0] best_frac_r;
  logic [CORR_WIDTH-1:0]     best_corr_r, result;
  logic                      result_ok;
  logic [TMR_W-1:0]          timer;

  // Fractional step carries into the integer part; integer part wraps naturally.
  logic [SFO_FRAC_WIDTH:0]   frac_sum;
  logic [SFO_INT_WIDTH-1:0]  next_int;
  logic [HYP_CNT_WIDTH-1:0]  count_inc;
  logic                      better;

  always_comb begin
    frac_sum  = {1'b0, hyp_frac} + {1'b0, step_r};
    next_int  = hyp_int + SFO_INT_WIDTH'(frac_sum[SFO_FRAC_WIDTH]);
    count_inc = count + 1'b1;
    better    = result_ok && (!best_valid_r || (result > best_corr_r));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      step_r       <= '0;
      num_r        <= '0;
      count        <= '0;
      addr         <= '0;
      rd_en        <= 1'b0;
      upd          <= 1'b0;
      corr_rst_r   <= 1'b0;
      hyp_int      <= '0;
      hyp_frac     <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      best_valid_r <= 1'b0;
      best_int_r   <= '0;
      best_frac_r  <= '0;
      best_corr_r  <= '0;
      timeout_r    <= 1'b0;
      result       <= '0;
      result_ok    <= 1'b0;
      timer        <= '0;
    end else begin
      done_r     <= 1'b0;
      corr_rst_r <= 1'b0;
      upd        <= rd_en;
      case (state)
        S_IDLE: if (bus.start) begin
          step_r       <= bus.sfo_step_frac;
          num_r        <= bus.num_hypotheses;
          count        <= '0;
          best_valid_r <= 1'b0;
          best_int_r   <= '0;
          best_frac_r  <= '0;
          best_corr_r  <= '0;
          timeout_r    <= 1'b0;
          if (bus.num_hypotheses == '0) begin
            state  <= S_FINISH;
            done_r <= 1'b1;
          end else begin
            state      <= S_LOAD;
            busy_r     <= 1'b1;
            corr_rst_r <= 1'b1;
            hyp_int    <= bus.sfo_start_int;
            hyp_frac   <= bus.sfo_start_frac;
          end
        end
        S_LOAD: begin
          state <= S_STREAM;
          rd_en <= 1'b1;
          addr  <= '0;
        end
        S_STREAM: begin
          if (addr == LAST_ADDR) begin
            rd_en <= 1'b0;
            addr  <= '0;
            state <= S_DRAIN;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        // Last bin's read data arrives now, with its update strobe.
        S_DRAIN: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.correlation_valid) begin
            result    <= bus.correlation_in;
            result_ok <= 1'b1;
            state     <= S_NEXT;
          end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            result    <= '0;
            result_ok <= 1'b0;
            timeout_r <= 1'b1;
            state     <= S_NEXT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_NEXT: begin
          if (better) begin
            best_valid_r <= 1'b1;
            best_int_r   <= hyp_int;
            best_frac_r  <= hyp_frac;
            best_corr_r  <= result;
          end
          count <= count_inc;
          if (count_inc == num_r) begin
            state  <= S_FINISH;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            hyp_int    <= next_int;
            hyp_frac   <= frac_sum[SFO_FRAC_WIDTH-1:0];
            corr_rst_r <= 1'b1;
            state      <= S_LOAD;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Reset also clears the downstream correlator in the same cycle.
  assign bus.correlation_reset  = corr_rst_r | reset;
  assign bus.correlation_update = upd;
  assign bus.fft_mag_out        = bus.mag_rd_data;
  assign bus.mag_rd_addr        = addr;
  assign bus.mag_rd_en          = rd_en;
  assign bus.sfo_int_part       = hyp_int;
  assign bus.sfo_frac_part      = hyp_frac;
  assign bus.busy               = busy_r;
  assign bus.done               = done_r;
  assign bus.best_valid         = best_valid_r;
  assign bus.best_sfo_int       = best_int_r;
  assign bus.best_sfo_frac      = best_frac_r;
  assign bus.best_corr          = best_corr_r;
  assign bus.timeout_seen       = timeout_r;
endmodule

// File: tb/tb_sfo_hypothesis_sweeper.sv
// Bench for sfo_hypothesis_sweeper: behavioural FFT buffer + correlator, directed and random sweeps
// checked against a plain-arithmetic reference of the hypothesis sweep.
module tb_sfo_hypothesis_sweeper;
  localparam int BINS = 512;
  localparam int TMO  = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sfo_hypothesis_sweeper_if bus();
  sfo_hypothesis_sweeper dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [BINS];
  logic [15:0] acc [BINS];
  int  lat = 4;
  int  drop_abs = -1;
  bit  force_const = 1'b0;
  int  upd_cnt = 0, countdown = -1, exp_addr = 0, cur_idx = 0;
  logic [24:0] cur_sfo = '0;
  logic [24:0] hyp_log [$];
  int  n_resets = 0, n_updates = 0, n_done = 0, prot_err = 0;

  // Score of a hypothesis: sum of bins at floor(k * sfo), k = 1, 2, ...
  function automatic logic [25:0] score(input logic [24:0] sfo, input bit from_acc);
    logic [25:0] s;
    longint p;
    s = '0;
    if (force_const) return 26'd12345;
    if (sfo == '0) return from_acc ? 26'(acc[0]) : 26'(mem[0]);
    for (int k = 1; k <= 8192; k++) begin
      p = (longint'(k) * longint'(sfo)) >> 16;
      if (p >= BINS) break;
      s += from_acc ? 26'(acc[int'(p)]) : 26'(mem[int'(p)]);
    end
    return s;
  endfunction

  // FFT buffer, correlator model and protocol monitor
  always @(posedge clk) begin
    if (reset) begin
      upd_cnt   <= 0;
      countdown <= -1;
      exp_addr  <= 0;
      bus.correlation_valid <= 1'b0;
      bus.correlation_in    <= '0;
      bus.mag_rd_data       <= '0;
    end else begin
      if (bus.done) n_done <= n_done + 1;
      if (bus.mag_rd_en) begin
        bus.mag_rd_data <= mem[bus.mag_rd_addr];
        if (int'(bus.mag_rd_addr) != exp_addr) prot_err <= prot_err + 1;
        exp_addr <= exp_addr + 1;
      end
      if (bus.correlation_reset) begin
        n_resets  <= n_resets + 1;
        cur_idx   <= hyp_log.size();
        hyp_log.push_back({bus.sfo_int_part, bus.sfo_frac_part});
        cur_sfo   <= {bus.sfo_int_part, bus.sfo_frac_part};
        upd_cnt   <= 0;
        countdown <= -1;
        exp_addr  <= 0;
        bus.correlation_valid <= 1'b0;
      end else if (bus.correlation_update) begin
        n_updates <= n_updates + 1;
        if (upd_cnt < BINS) acc[upd_cnt] <= bus.fft_mag_out;
        else prot_err <= prot_err + 1;
        upd_cnt <= upd_cnt + 1;
        if (upd_cnt == BINS - 1) countdown <= lat;
      end else if (countdown > 0) begin
        countdown <= countdown - 1;
      end else if (countdown == 0) begin
        countdown <= -1;
        if (cur_idx != drop_abs) begin
          bus.correlation_valid <= 1'b1;
          bus.correlation_in    <= score(cur_sfo, 1'b1);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_sweep(input string tag, input logic [8:0] si, input logic [15:0] sf,
                           input logic [15:0] st, input int n, input int drop,
                           input int latency, input bit fc, input bit poke);
    logic [24:0] h, bhyp;
    logic [24:0] exp_list [$];
    logic [25:0] sc, bcorr;
    bit bok, tmo, seen, lmis;
    int base_log, b_res, b_upd, b_done, b_perr, cyc, budget;
    lat = latency;
    force_const = fc;
    base_log = hyp_log.size();
    drop_abs = (drop < 0) ? -1 : base_log + drop;
    b_res = n_resets; b_upd = n_updates; b_done = n_done; b_perr = prot_err;
    // reference sweep
    h = {si, sf}; bok = 1'b0; tmo = 1'b0; bcorr = '0; bhyp = '0;
    for (int i = 0; i < n; i++) begin
      exp_list.push_back(h);
      if (i == drop) tmo = 1'b1;
      else begin
        sc = score(h, 1'b0);
        if (!bok || sc > bcorr) begin bok = 1'b1; bcorr = sc; bhyp = h; end
      end
      h = h + {9'd0, st};
    end
    bus.sfo_start_int  = si;
    bus.sfo_start_frac = sf;
    bus.sfo_step_frac  = st;
    bus.num_hypotheses = 8'(n);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = bus.done;
    cyc = 0;
    budget = n * (BINS + latency + TMO + 8) + 16;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 40) begin
        bus.start = 1'b1; bus.sfo_start_int = si + 9'd3; bus.num_hypotheses = 8'd0;
      end else if (poke && cyc == 41) begin
        bus.start = 1'b0;
      end
      seen = bus.done;
    end
    chk({tag, " done seen"}, 64'(seen), 64'd1);
    if (n == 0) chk({tag, " done latency"}, 64'(cyc), 64'd0);
    repeat (3) @(negedge clk);
    chk({tag, " done pulses"}, 64'(n_done - b_done), 64'd1);
    chk({tag, " busy idle"}, 64'(bus.busy), 64'd0);
    chk({tag, " best_valid"}, 64'(bus.best_valid), 64'(bok));
    if (bok) begin
      chk({tag, " best_int"},  64'(bus.best_sfo_int),  64'(bhyp[24:16]));
      chk({tag, " best_frac"}, 64'(bus.best_sfo_frac), 64'(bhyp[15:0]));
      chk({tag, " best_corr"}, 64'(bus.best_corr),     64'(bcorr));
    end
    chk({tag, " timeout_seen"}, 64'(bus.timeout_seen), 64'(tmo));
    chk({tag, " corr resets"},  64'(n_resets - b_res),  64'(n));
    chk({tag, " corr updates"}, 64'(n_updates - b_upd), 64'(n * BINS));
    chk({tag, " addr order"},   64'(prot_err - b_perr), 64'd0);
    lmis = (hyp_log.size() - base_log) != n;
    if (!lmis)
      for (int i = 0; i < n; i++)
        if (hyp_log[base_log + i] !== exp_list[i]) lmis = 1'b1;
    chk({tag, " hyp sequence"}, 64'(lmis), 64'd0);
  endtask

  task automatic fill_peaks();
    for (int i = 0; i < BINS; i++) mem[i] = 16'($urandom_range(0, 3));
    for (int k = 1; (9 * k) / 2 < BINS; k++) mem[(9 * k) / 2] = 16'd1000;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.sfo_start_int = '0; bus.sfo_start_frac = '0;
    bus.sfo_step_frac = '0; bus.num_hypotheses = '0;
    for (int i = 0; i < BINS; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset busy",        64'(bus.busy), 64'd0);
    chk("reset done",        64'(bus.done), 64'd0);
    chk("reset best_valid",  64'(bus.best_valid), 64'd0);
    chk("reset timeout",     64'(bus.timeout_seen), 64'd0);
    chk("reset rd_en",       64'(bus.mag_rd_en), 64'd0);
    chk("reset corr_reset",  64'(bus.correlation_reset), 64'd1);
    chk("reset best_corr",   64'(bus.best_corr), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 4.5-bin peak grid: hypotheses 4.0, 4.25, 4.5, 4.75
    fill_peaks();
    run_sweep("peak", 9'd4, 16'h0000, 16'h4000, 4, -1, 5, 1'b0, 1'b0);
    chk("peak winner int",  64'(bus.best_sfo_int),  64'd4);
    chk("peak winner frac", 64'(bus.best_sfo_frac), 64'h8000);

    run_sweep("carry", 9'd5,   16'hC000, 16'h8000, 3, -1, 3, 1'b0, 1'b0);
    run_sweep("wrap",  9'd511, 16'hC000, 16'h8000, 2, -1, 2, 1'b0, 1'b0);

    run_sweep("tie", 9'd3, 16'h1234, 16'h2000, 4, -1, 7, 1'b1, 1'b0);
    chk("tie keeps first", 64'(bus.best_sfo_frac), 64'h1234);

    run_sweep("timeout", 9'd4, 16'h0000, 16'h4000, 4, 2, 4, 1'b0, 1'b0);
    chk("timeout not chosen", 64'(bus.best_sfo_frac == 16'h8000), 64'd0);

    run_sweep("empty", 9'd7, 16'h0000, 16'h1000, 0, -1, 1, 1'b0, 1'b0);

    // reset in the middle of streaming
    bus.sfo_start_int = 9'd6; bus.sfo_start_frac = 16'h0; bus.sfo_step_frac = 16'h1000;
    bus.num_hypotheses = 8'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid busy",  64'(bus.busy), 64'd1);
    chk("mid rd_en", 64'(bus.mag_rd_en), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset busy",       64'(bus.busy), 64'd0);
    chk("midreset done",       64'(bus.done), 64'd0);
    chk("midreset best_valid", 64'(bus.best_valid), 64'd0);
    chk("midreset rd_en",      64'(bus.mag_rd_en), 64'd0);
    chk("midreset update",     64'(bus.correlation_update), 64'd0);
    chk("midreset corr_reset", 64'(bus.correlation_reset), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    fill_peaks();
    run_sweep("after reset", 9'd4, 16'h0000, 16'h4000, 4, -1, 6, 1'b0, 1'b1);

    for (int r = 0; r < 5; r++) begin
      int n, drop;
      for (int i = 0; i < BINS; i++)
        mem[i] = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 2000)) : 16'($urandom_range(0, 7));
      n = $urandom_range(1, 4);
      drop = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      run_sweep($sformatf("rand%0d", r), 9'($urandom_range(2, 12)), 16'($urandom),
                16'($urandom), n, drop, $urandom_range(1, 30), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
